bpu_update_queue: RTL
=====================

BPU_UPDATE_QUEUE -- requirements
Module: bpu_update_queue

Interface
REQ-001 SHALL have parameter Cfg, default config_pkg::EmptyCfg, which supplies NRET, PLEN and ILEN.
REQ-002 SHALL have parameter DEPTH, default 8, giving the number of queue entries; DEPTH is a power of 2 and DEPTH >= Cfg.NRET.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports, in the form name, direction, width, meaning:
- clk_i, in, 1, clock.
- rst_ni, in, 1, async active-low reset.
- commit_valid_i, in, NRET, retiring slot valid.
- commit_is_ctrl_i, in, NRET, slot is a control-transfer instruction.
- commit_is_cond_i, in, NRET, conditional branch.
- commit_taken_i, in, NRET, resolved taken.
- commit_is_call_i, in, NRET, call.
- commit_is_ret_i, in, NRET, return.
- commit_pc_i, in, NRET x PLEN, slot PC.
- commit_target_i, in, NRET x PLEN, resolved target.
- update_valid_o, out, 1, drives BPU update_valid_i.
- update_pc_o, update_target_o, out, PLEN, PC and target of the head entry.
- update_is_cond_o, update_taken_o, update_is_call_o, update_is_ret_o, out, 1, type flags of the head entry.
- ready_o, out, 1, free entries >= NRET (advisory only).
- count_o, out, clog2(DEPTH+1), occupancy.
- drop_cnt_o, out, 16, saturating count of dropped updates.

Function
REQ-005 SHALL define a slot as eligible when commit_valid_i[i] && commit_is_ctrl_i[i]; non-eligible slots are ignored and never counted as drops.
REQ-006 SHALL compact eligible slots in ascending slot index into consecutive entries starting at the tail.
REQ-007 SHALL accept all-or-nothing: when n = popcount(eligible) <= free entries, all n are pushed; otherwise none are pushed and drop_cnt_o increases by n, saturating at 0xFFFF.
REQ-008 SHALL compute free entries from start-of-cycle occupancy minus the pop occurring in that cycle (pop frees a slot the same cycle).
REQ-009 SHALL pop exactly one entry every cycle in which the queue is non-empty; the BPU has no backpressure.
REQ-010 SHALL drive the update_*_o fields from the head entry whenever update_valid_o=1, and drive them to 0 when the queue is empty.
REQ-011 SHALL have push-to-visible latency of 1 cycle: an entry pushed at edge N may appear at the head in cycle N+1, with no combinational bypass.
REQ-012 SHALL update occupancy as count_next = count + n_pushed - pop; simultaneous push and pop are legal at any occupancy, including full with pop.
REQ-013 SHALL use head and tail pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH; empty is head==tail; full is equal index bits with differing MSB.
REQ-014 SHALL leave flush unaffected: there is no flush input, and committed updates are always delivered.
REQ-015 SHALL preserve order: output order equals commit order, and equals slot order within a cycle.

Reset
REQ-016 SHALL, while rst_ni=0, hold head, tail and count at 0, drop_cnt_o at 0, update_valid_o at 0, all update_*_o at 0, and ready_o at 1.
REQ-017 SHALL discard all queued entries on reset asserted mid-operation, with outputs taking their reset values immediately (asynchronously).

Structure
REQ-018 SHALL place the entry struct bpu_update_t (pc, target, is_cond, taken, is_call, is_ret) in global_config_pkg, to be shared with the BPU.
REQ-019 SHALL implement slot compaction as one combinational sub-module, bpu_update_compact: eligible mask to packed entries plus count n.
REQ-020 SHALL hold storage in flops (DEPTH x bpu_update_t), with no SRAM macro.

Verification (bench: NRET=2, DEPTH=4, PLEN=32)
REQ-021 Single push: slot0 call pc=0x100, target=0x200 -> next cycle update_valid_o=1, pc=0x100, is_call=1; following cycle update_valid_o=0, count_o=0.
REQ-022 Compaction: slot0 non-ctrl, slot1 cond taken pc=0x304 -> one entry pc=0x304; count_o=1 after the edge.
REQ-023 Ordering: cycle A slots {0x10,0x14}, cycle B slots {0x20,0x24} -> outputs 0x10, 0x14, 0x20, 0x24 on consecutive cycles.
REQ-024 Overflow: count=4, no pop possible in that cycle (queue full, head popped earlier test-controlled via preload), 2 eligible -> nothing pushed, drop_cnt_o += 2; with count=3 plus a pop, 2 eligible -> both accepted, count_o=4.
REQ-025 Wrap: push 10 entries in pairs over time -> pointers wrap and all 10 appear in order with drop_cnt_o=0.
REQ-026 Reset: assert rst_ni=0 with count=3 -> update_valid_o=0 and count_o=0 in the same cycle; after release, the first new push is seen 1 cycle later.

Source files
------------

// File: rtl/bpu_update_queue_pkg.sv
// Local constants and helpers for the BPU update queue.
// drop_sat_add: 16-bit add that sticks at all-ones instead of wrapping.
package bpu_update_queue_pkg;

  localparam int unsigned DropCntW = 16;

  function automatic logic [DropCntW-1:0] drop_sat_add(input logic [DropCntW-1:0] cnt,
                                                       input logic [DropCntW-1:0] inc);
    logic [DropCntW:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    return sum[DropCntW] ? '1 : sum[DropCntW-1:0];
  endfunction

endpackage

// File: rtl/config_pkg.sv
// Core-level configuration record shared by the front-end blocks.
// cfg_t carries the retire width (NRET), physical address width (PLEN) and
// instruction width (ILEN). EmptyCfg is the default configuration used when
// a block is instantiated without an explicit core configuration.
package config_pkg;

  localparam int unsigned DefaultPlen = 32;

  typedef struct packed {
    int unsigned NRET;
    int unsigned PLEN;
    int unsigned ILEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{NRET: 2, PLEN: DefaultPlen, ILEN: 32};

endpackage

// File: rtl/global_config_pkg.sv
// Types shared between the commit stage and the branch predictor.
// bpu_update_t is one resolved control-transfer record as consumed by the
// BPU update port. Its address width follows the default core PLEN, so any
// core configuration using this record must keep PLEN at that value.
package global_config_pkg;

  localparam int unsigned UpdPlen = config_pkg::DefaultPlen;

  typedef struct packed {
    logic [UpdPlen-1:0] pc;
    logic [UpdPlen-1:0] target;
    logic               is_cond;
    logic               taken;
    logic               is_call;
    logic               is_ret;
  } bpu_update_t;

endpackage

// File: rtl/bpu_update_queue_if.sv
// BPU update bus: one record per cycle, no backpressure.
//   valid : entry carries a live update
//   entry : head record of the update queue (all zero when not valid)
// master = update queue side, slave = branch predictor side.
interface bpu_update_queue_if;
  import global_config_pkg::*;

  logic        valid;
  bpu_update_t entry;

  modport master (output valid, entry);
  modport slave  (input  valid, entry);
endinterface

// File: rtl/bpu_update_compact.sv
// Packs the eligible retire slots (valid && control-transfer) into a dense
// list, lowest slot index first.
//   valid_i/is_ctrl_i/is_*_i/taken_i : per-slot retire flags
//   pc_i/target_i                    : per-slot PC and resolved target
//   entries_o                        : packed records, entries_o[0] first
//   n_o                              : number of valid records in entries_o
module bpu_update_compact
  import global_config_pkg::*;
#(
  parameter int unsigned NRET = 2,
  parameter int unsigned NW   = $clog2(NRET + 1)
) (
  input  logic [NRET-1:0]              valid_i,
  input  logic [NRET-1:0]              is_ctrl_i,
  input  logic [NRET-1:0]              is_cond_i,
  input  logic [NRET-1:0]              taken_i,
  input  logic [NRET-1:0]              is_call_i,
  input  logic [NRET-1:0]              is_ret_i,
  input  logic [NRET-1:0][UpdPlen-1:0] pc_i,
  input  logic [NRET-1:0][UpdPlen-1:0] target_i,
  output bpu_update_t [NRET-1:0]       entries_o,
  output logic [NW-1:0]                n_o
);

  logic [NRET-1:0] elig;
  logic [NW-1:0]   pos [NRET];  // destination index of each slot
  logic [NW-1:0]   run;

  assign elig = valid_i & is_ctrl_i;

  // Exclusive prefix count of eligible slots gives each slot its output position.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    run = '0;
    for (int i = 0; i < NRET; i++) begin
      pos[i] = run;
      if (elig[i]) run = run + NW'(1);
    end
  end

  assign n_o = run;

  always_comb begin
    entries_o = '0;
    for (int j = 0; j < NRET; j++) begin
      for (int i = 0; i < NRET; i++) begin
        if (elig[i] && pos[i] == NW'(j)) begin
          entries_o[j] = '{pc: pc_i[i], target: target_i[i], is_cond: is_cond_i[i],
                           taken: taken_i[i], is_call: is_call_i[i], is_ret: is_ret_i[i]};
        end
      end
    end
  end

endmodule

// File: rtl/bpu_update_queue.sv
// Decouples retire from the branch predictor: resolved control transfers
// from up to NRET retire slots per cycle are queued and replayed to the BPU
// one per cycle. A retire group that does not fit is dropped as a whole and
// counted.
//   clk_i, rst_ni        : clock, async active-low reset
//   commit_*_i           : per-slot retire information
//   update_*_o           : head record (zero when empty); update_valid_o = non-empty
//   upd_if               : same head record as a bundled bus for the BPU
//   ready_o              : at least NRET entries free this cycle (advisory)
//   count_o              : occupancy
//   drop_cnt_o           : saturating count of dropped updates
module bpu_update_queue
  import global_config_pkg::*;
  import bpu_update_queue_pkg::*;
#(
  parameter config_pkg::cfg_t Cfg   = config_pkg::EmptyCfg,
  parameter int unsigned      DEPTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [Cfg.NRET-1:0]                commit_valid_i,
  input  logic [Cfg.NRET-1:0]                commit_is_ctrl_i,
  input  logic [Cfg.NRET-1:0]                commit_is_cond_i,
  input  logic [Cfg.NRET-1:0]                commit_taken_i,
  input  logic [Cfg.NRET-1:0]                commit_is_call_i,
  input  logic [Cfg.NRET-1:0]                commit_is_ret_i,
  input  logic [Cfg.NRET-1:0][Cfg.PLEN-1:0]  commit_pc_i,
  input  logic [Cfg.NRET-1:0][Cfg.PLEN-1:0]  commit_target_i,
  output logic                               update_valid_o,
  output logic [Cfg.PLEN-1:0]                update_pc_o,
  output logic [Cfg.PLEN-1:0]                update_target_o,
  output logic                               update_is_cond_o,
  output logic                               update_taken_o,
  output logic                               update_is_call_o,
  output logic                               update_is_ret_o,
  output logic                               ready_o,
  output logic [$clog2(DEPTH+1)-1:0]         count_o,
  output logic [DropCntW-1:0]                drop_cnt_o,
  bpu_update_queue_if.master                 upd_if
);

  localparam int unsigned NRET = Cfg.NRET;
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;  // extra MSB separates full from empty
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned NW   = $clog2(NRET + 1);

  bpu_update_t            mem_q [DEPTH];
  logic [PtrW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [DropCntW-1:0]    drop_q, drop_d;
  bpu_update_t [NRET-1:0] entries;
  logic [NW-1:0]          n_elig;
  logic [PtrW-1:0]        occ;
  logic [PtrW:0]          free;
  logic                   empty, pop, accept;
  logic [NRET-1:0]        wr_en;
  logic [IdxW-1:0]        wr_idx [NRET];
  bpu_update_t            head_entry;

  bpu_update_compact #(.NRET(NRET), .NW(NW)) u_compact (
    .valid_i   (commit_valid_i),
    .is_ctrl_i (commit_is_ctrl_i),
    .is_cond_i (commit_is_cond_i),
    .taken_i   (commit_taken_i),
    .is_call_i (commit_is_call_i),
    .is_ret_i  (commit_is_ret_i),
    .pc_i      (commit_pc_i),
    .target_i  (commit_target_i),
    .entries_o (entries),
    .n_o       (n_elig)
  );

  assign occ    = tail_q - head_q;
  assign empty  = (head_q == tail_q);
  assign pop    = !empty;  // BPU always consumes the head
  // The entry popped this cycle frees its slot for this cycle's push.
  assign free   = (PtrW+1)'(DEPTH) - (PtrW+1)'(occ) + (PtrW+1)'(pop);
  assign accept = ((PtrW+1)'(n_elig) <= free);

  always_comb begin
    head_d = head_q + PtrW'(pop);
    tail_d = tail_q;
    drop_d = drop_q;
    wr_en  = '0;
    for (int i = 0; i < NRET; i++) wr_idx[i] = IdxW'(tail_q + PtrW'(i));
    if (accept) begin
      tail_d = tail_q + PtrW'(n_elig);
      for (int i = 0; i < NRET; i++) wr_en[i] = (NW'(i) < n_elig);
    end else begin
      drop_d = drop_sat_add(drop_q, DropCntW'(n_elig));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      drop_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      drop_q <= drop_d;
    end
  end

  // NOTE: storage has no reset; the pointers define validity and empty masks the outputs.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRET; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= entries[i];
    end
  end

  assign head_entry       = empty ? bpu_update_t'('0) : mem_q[head_q[IdxW-1:0]];

  assign update_valid_o   = pop;
  assign update_pc_o      = head_entry.pc;
  assign update_target_o  = head_entry.target;
  assign update_is_cond_o = head_entry.is_cond;
  assign update_taken_o   = head_entry.taken;
  assign update_is_call_o = head_entry.is_call;
  assign update_is_ret_o  = head_entry.is_ret;
  assign ready_o          = (free >= (PtrW+1)'(NRET));
  assign count_o          = CntW'(occ);
  assign drop_cnt_o       = drop_q;

  assign upd_if.valid     = pop;
  assign upd_if.entry     = head_entry;

endmodule
